// File: rtl/lfsr_bist_seq.sv
// March-style memory BIST sequencer: writes a 16-bit Fibonacci LFSR pattern to every
// address, re-seeds, reads everything back and reports pass/fail, first failing address and count.
module lfsr_bist_seq #(
    parameter int ADDR_W = 8,
    parameter int RD_LAT = 1,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start,
    input  logic              abort,
    input  logic [15:0]       seed_in,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_wdata,
    input  logic [15:0]       mem_rdata,
    output logic              busy,
    output logic              done,
    output logic              fail,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [CNT_W-1:0]  fail_cnt,
    output logic [2:0]        dbg_state
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_WR     = 3'd1;
    localparam logic [2:0] S_RESEED = 3'd2;
    localparam logic [2:0] S_RD     = 3'd3;
    localparam logic [2:0] S_DRAIN  = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;

    logic [2:0]        r_state;
    logic [15:0]       r_lfsr;
    logic [15:0]       r_seed;
    logic [ADDR_W-1:0] r_addr;
    logic [2:0]        r_drain;
    logic [RD_LAT-1:0] r_pv;
    logic [15:0]       r_pdata [RD_LAT];
    logic [ADDR_W-1:0] r_paddr [RD_LAT];
    logic              r_fail;
    logic [ADDR_W-1:0] r_fail_addr;
    logic [CNT_W-1:0]  r_fail_cnt;

    logic [15:0] w_lfsr_next;
    logic [15:0] w_seed;
    logic        w_last;
    logic        w_launch;
    logic        w_push;
    logic        w_miss;

    assign w_lfsr_next = {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
    // An all-zero seed would lock the LFSR at zero forever.
    assign w_seed      = (seed_in == 16'h0000) ? 16'h0001 : seed_in;
    assign w_last      = &r_addr;
    assign w_launch    = !abort && start && (r_state == S_IDLE || r_state == S_DONE);
    assign w_push      = !abort && (r_state == S_RD);
    assign w_miss      = r_pv[RD_LAT-1] && (mem_rdata != r_pdata[RD_LAT-1]);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= S_IDLE;
            r_lfsr  <= 16'h0001;
            r_seed  <= 16'h0001;
            r_addr  <= '0;
            r_drain <= '0;
        end else if (abort) begin
            r_state <= S_IDLE;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_seed  <= w_seed;
                        r_lfsr  <= w_seed;
                        r_addr  <= '0;
                        r_state <= S_WR;
                    end
                end
                S_WR: begin
                    r_lfsr <= w_lfsr_next;
                    r_addr <= r_addr + ADDR_W'(1);
                    if (w_last) r_state <= S_RESEED;
                end
                S_RESEED: begin
                    r_lfsr  <= r_seed;
                    r_state <= S_RD;
                end
                S_RD: begin
                    r_lfsr <= w_lfsr_next;
                    r_addr <= r_addr + ADDR_W'(1);
                    if (w_last) begin
                        r_drain <= '0;
                        r_state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    r_drain <= r_drain + 3'd1;
                    if (r_drain == 3'(RD_LAT - 1)) r_state <= S_DONE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Expect pipeline mirrors the SRAM read latency so each entry meets its own read data.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_pv        <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                r_pdata[i] <= '0;
                r_paddr[i] <= '0;
            end
            r_fail      <= 1'b0;
            r_fail_addr <= '0;
            r_fail_cnt  <= '0;
        end else begin
            r_pv[0]    <= w_push;
            r_pdata[0] <= r_lfsr;
            r_paddr[0] <= r_addr;
            for (int i = 1; i < RD_LAT; i++) begin
                r_pv[i]    <= r_pv[i-1];
                r_pdata[i] <= r_pdata[i-1];
                r_paddr[i] <= r_paddr[i-1];
            end
            if (abort) r_pv <= '0;
            if (w_launch) begin
                r_fail      <= 1'b0;
                r_fail_addr <= '0;
                r_fail_cnt  <= '0;
            end else if (!abort && w_miss) begin
                r_fail <= 1'b1;
                if (!r_fail) r_fail_addr <= r_paddr[RD_LAT-1];
                if (r_fail_cnt != {CNT_W{1'b1}}) r_fail_cnt <= r_fail_cnt + CNT_W'(1);
            end
        end
    end

    assign mem_en    = (r_state == S_WR) || (r_state == S_RD);
    assign mem_we    = (r_state == S_WR);
    assign mem_addr  = mem_en ? r_addr : '0;
    assign mem_wdata = mem_we ? r_lfsr : 16'h0000;
    assign busy      = (r_state == S_WR) || (r_state == S_RESEED) ||
                       (r_state == S_RD) || (r_state == S_DRAIN);
    assign done      = (r_state == S_DONE);
    assign fail      = r_fail;
    assign fail_addr = r_fail_addr;
    assign fail_cnt  = r_fail_cnt;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_lfsr_bist_seq.sv
// Bench for lfsr_bist_seq: three instances (clean, CNT_W=2, RD_LAT=3) share stimulus,
// each with its own SRAM model and per-address fault masks.
module tb_lfsr_bist_seq;
    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_DONE = 3'd5;

    logic        clk     = 1'b0;
    logic        rstn    = 1'b1;
    logic        start   = 1'b0;
    logic        abort   = 1'b0;
    logic [15:0] seed_in = 16'h0000;

    logic [2:0]        en, we, busy, done, fail;
    logic [2:0][3:0]   addr, faddr;
    logic [2:0][15:0]  wdata, rdata;
    logic [2:0][2:0]   st;
    logic [7:0]        cnt0, cnt2;
    logic [1:0]        cnt1;

    logic [15:0] mem  [3][16];
    logic [15:0] rp   [3][3];
    logic [15:0] or_m [3][16];
    logic [15:0] xr_m [3][16];

    logic [19:0] exp_q[$];
    int          n_pass = 0;
    int          n_total = 0;
    int          sb_err;
    int          busy_cnt [3];
    logic [15:0] first_w [3];
    logic [15:0] second_w [3];
    logic        timed_out;
    logic        s_busy, s_done, s_en;
    logic [2:0]  s_st;

    always #5 clk = ~clk;

    lfsr_bist_seq #(.ADDR_W(4), .RD_LAT(1), .CNT_W(8)) u_a (
        .clk(clk), .rstn(rstn), .start(start), .abort(abort), .seed_in(seed_in),
        .mem_en(en[0]), .mem_we(we[0]), .mem_addr(addr[0]), .mem_wdata(wdata[0]),
        .mem_rdata(rdata[0]), .busy(busy[0]), .done(done[0]), .fail(fail[0]),
        .fail_addr(faddr[0]), .fail_cnt(cnt0), .dbg_state(st[0]));

    lfsr_bist_seq #(.ADDR_W(4), .RD_LAT(1), .CNT_W(2)) u_b (
        .clk(clk), .rstn(rstn), .start(start), .abort(abort), .seed_in(seed_in),
        .mem_en(en[1]), .mem_we(we[1]), .mem_addr(addr[1]), .mem_wdata(wdata[1]),
        .mem_rdata(rdata[1]), .busy(busy[1]), .done(done[1]), .fail(fail[1]),
        .fail_addr(faddr[1]), .fail_cnt(cnt1), .dbg_state(st[1]));

    lfsr_bist_seq #(.ADDR_W(4), .RD_LAT(3), .CNT_W(8)) u_c (
        .clk(clk), .rstn(rstn), .start(start), .abort(abort), .seed_in(seed_in),
        .mem_en(en[2]), .mem_we(we[2]), .mem_addr(addr[2]), .mem_wdata(wdata[2]),
        .mem_rdata(rdata[2]), .busy(busy[2]), .done(done[2]), .fail(fail[2]),
        .fail_addr(faddr[2]), .fail_cnt(cnt2), .dbg_state(st[2]));

    // SRAM models: stuck/flip masks applied on the read path only.
    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (en[k] && we[k]) mem[k][addr[k]] <= wdata[k];
            rp[k][0] <= (en[k] && !we[k]) ?
                        ((mem[k][addr[k]] | or_m[k][addr[k]]) ^ xr_m[k][addr[k]]) : 16'h0000;
            rp[k][1] <= rp[k][0];
            rp[k][2] <= rp[k][1];
        end
    end
    assign rdata[0] = rp[0][0];
    assign rdata[1] = rp[1][0];
    assign rdata[2] = rp[2][2];

    function automatic logic [15:0] lfsr_next(input logic [15:0] x);
        return {x[14:0], x[15] ^ x[13] ^ x[12] ^ x[10]};
    endfunction

    function automatic logic [15:0] model_word(input logic [15:0] seed, input int a);
        logic [15:0] x;
        x = (seed == 16'h0000) ? 16'h0001 : seed;
        for (int i = 0; i < a; i++) x = lfsr_next(x);
        return x;
    endfunction

    task automatic clear_faults();
        for (int k = 0; k < 3; k++)
            for (int a = 0; a < 16; a++) begin
                or_m[k][a] = 16'h0000;
                xr_m[k][a] = 16'h0000;
            end
    endtask

    task automatic run_test(input logic [15:0] s, input int abort_cyc, input int restart_cyc);
        int          cyc;
        logic [15:0] x;
        logic [19:0] e;
        exp_q.delete();
        x = (s == 16'h0000) ? 16'h0001 : s;
        for (int a = 0; a < 16; a++) begin
            exp_q.push_back({4'(a), x});
            x = lfsr_next(x);
        end
        sb_err = 0;
        timed_out = 1'b0;
        for (int k = 0; k < 3; k++) begin
            busy_cnt[k] = 0;
            first_w[k]  = 16'hDEAD;
            second_w[k] = 16'hDEAD;
        end
        s_busy = 1'b1; s_done = 1'b1; s_en = 1'b1; s_st = 3'd7;
        @(negedge clk);
        seed_in = s;
        start   = 1'b1;
        cyc     = 0;
        forever begin
            @(negedge clk);
            cyc++;
            for (int k = 0; k < 3; k++) begin
                if (busy[k]) busy_cnt[k]++;
                if (en[k] && we[k] && addr[k] == 4'd0) first_w[k] = wdata[k];
                if (en[k] && we[k] && addr[k] == 4'd1) second_w[k] = wdata[k];
            end
            if (en[0] && we[0]) begin
                if (exp_q.size() == 0) sb_err++;
                else begin
                    e = exp_q.pop_front();
                    if ({addr[0], wdata[0]} !== e) sb_err++;
                end
            end
            if (cyc == abort_cyc + 1) begin
                s_busy = busy[0]; s_done = done[0]; s_en = en[0]; s_st = st[0];
            end
            start = (cyc == restart_cyc);
            abort = (cyc == abort_cyc);
            if (busy == 3'b000) break;
            if (cyc >= 300) begin
                timed_out = 1'b1;
                break;
            end
        end
        start = 1'b0;
        abort = 1'b0;
    endtask

    task automatic test_reset();
        #1 rstn = 1'b0;
        #1;
        n_total++; if ({en[0], we[0], busy[0], done[0], fail[0], addr[0], wdata[0], faddr[0], cnt0, st[0]} !== '0)
            $display("FAIL reset_outputs: got %0h want 0", {en[0], we[0], busy[0], done[0], fail[0], addr[0], wdata[0], faddr[0], cnt0, st[0]}); else n_pass++;
        @(negedge clk) rstn = 1'b1;
        repeat (3) @(negedge clk);
        n_total++; if ({busy[0], st[0]} !== {1'b0, ST_IDLE})
            $display("FAIL idle_after_reset: got busy=%0b st=%0d want busy=0 st=0", busy[0], st[0]); else n_pass++;
        seed_in = 16'hACE1;
        start = 1'b1;
        @(negedge clk) start = 1'b0;
        repeat (2) @(negedge clk);
        n_total++; if ({busy[0], en[0], we[0]} !== 3'b111)
            $display("FAIL wr_active: got %0b want 111", {busy[0], en[0], we[0]}); else n_pass++;
        #2 rstn = 1'b0;
        #1;
        n_total++; if ({en, we, busy, done, fail, addr, wdata, faddr, cnt0, cnt1, cnt2} !== '0)
            $display("FAIL async_reset_mid_wr: got en=%0b busy=%0b wdata=%0h want all 0", en, busy, wdata); else n_pass++;
        @(negedge clk) rstn = 1'b1;
        repeat (4) @(negedge clk);
        n_total++; if ({busy[0], en[0], st[0]} !== {2'b00, ST_IDLE})
            $display("FAIL stays_idle: got busy=%0b en=%0b st=%0d want 0 0 0", busy[0], en[0], st[0]); else n_pass++;
    endtask

    task automatic test_clean();
        clear_faults();
        run_test(16'hACE1, 0, 0);
        n_total++; if (timed_out !== 1'b0) $display("FAIL clean_timeout: got %0b want 0", timed_out); else n_pass++;
        n_total++; if (sb_err !== 0 || exp_q.size() !== 0)
            $display("FAIL clean_wr_stream: got err=%0d left=%0d want 0 0", sb_err, exp_q.size()); else n_pass++;
        n_total++; if (first_w[0] !== 16'hACE1) $display("FAIL clean_wdata0: got %h want ace1", first_w[0]); else n_pass++;
        n_total++; if (second_w[0] !== 16'h59C3) $display("FAIL clean_wdata1: got %h want 59c3", second_w[0]); else n_pass++;
        n_total++; if (busy_cnt[0] !== 34) $display("FAIL clean_busy_len: got %0d want 34", busy_cnt[0]); else n_pass++;
        n_total++; if ({done[0], fail[0], cnt0, st[0]} !== {2'b10, 8'd0, ST_DONE})
            $display("FAIL clean_result: got done=%0b fail=%0b cnt=%0d want 1 0 0", done[0], fail[0], cnt0); else n_pass++;
    endtask

    task automatic test_stuck_at();
        logic [15:0] s, w;
        logic        exp_fail;
        clear_faults();
        or_m[0][5] = 16'h0008;
        s = 16'hACE1;
        for (int it = 0; it < 2; it++) begin
            if (it == 1) begin
                for (int t = 0; t < 200; t++) begin
                    s = 16'($urandom_range(1, 65535));
                    w = model_word(s, 5);
                    if (w[3] == 1'b0) break;
                end
            end
            w = model_word(s, 5);
            exp_fail = ~w[3];
            run_test(s, 0, 0);
            n_total++; if (fail[0] !== exp_fail) $display("FAIL stuck_fail seed=%h: got %0b want %0b", s, fail[0], exp_fail); else n_pass++;
            n_total++; if (faddr[0] !== (exp_fail ? 4'd5 : 4'd0))
                $display("FAIL stuck_addr seed=%h: got %0d want %0d", s, faddr[0], exp_fail ? 5 : 0); else n_pass++;
            n_total++; if (cnt0 !== {7'd0, exp_fail}) $display("FAIL stuck_cnt seed=%h: got %0d want %0d", s, cnt0, exp_fail); else n_pass++;
        end
    endtask

    task automatic test_saturation();
        logic [15:0] s;
        clear_faults();
        xr_m[1][2] = 16'h0001;
        xr_m[1][7] = 16'h0001;
        xr_m[1][9] = 16'h0001;
        xr_m[1][12] = 16'h0001;
        s = 16'($urandom_range(1, 65535));
        run_test(s, 0, 0);
        n_total++; if (sb_err !== 0 || exp_q.size() !== 0)
            $display("FAIL sat_wr_stream seed=%h: got err=%0d left=%0d want 0 0", s, sb_err, exp_q.size()); else n_pass++;
        n_total++; if ({done[1], fail[1], faddr[1], cnt1} !== {2'b11, 4'd2, 2'd3})
            $display("FAIL sat_result: got done=%0b fail=%0b addr=%0d cnt=%0d want 1 1 2 3", done[1], fail[1], faddr[1], cnt1); else n_pass++;
        n_total++; if (fail[0] !== 1'b0) $display("FAIL sat_clean_neighbour: got %0b want 0", fail[0]); else n_pass++;
    endtask

    task automatic test_zero_seed();
        clear_faults();
        run_test(16'h0000, 0, 0);
        n_total++; if (first_w[2] !== 16'h0001) $display("FAIL zero_seed_wdata0: got %h want 0001", first_w[2]); else n_pass++;
        n_total++; if (busy_cnt[2] !== 36) $display("FAIL lat3_busy_len: got %0d want 36", busy_cnt[2]); else n_pass++;
        n_total++; if ({done[2], fail[2], cnt2} !== {2'b10, 8'd0})
            $display("FAIL lat3_result: got done=%0b fail=%0b cnt=%0d want 1 0 0", done[2], fail[2], cnt2); else n_pass++;
        n_total++; if (sb_err !== 0 || busy_cnt[0] !== 34)
            $display("FAIL zero_seed_lat1: got err=%0d busy=%0d want 0 34", sb_err, busy_cnt[0]); else n_pass++;
    endtask

    task automatic test_abort_priority();
        clear_faults();
        xr_m[0][0] = 16'h0100;
        run_test(16'hACE1, 20, 0);
        n_total++; if ({s_busy, s_done, s_en, s_st} !== {3'b000, ST_IDLE})
            $display("FAIL abort_rd: got busy=%0b done=%0b en=%0b st=%0d want 0 0 0 0", s_busy, s_done, s_en, s_st); else n_pass++;
        n_total++; if ({fail[0], faddr[0], cnt0} !== {1'b1, 4'd0, 8'd1})
            $display("FAIL abort_hold: got fail=%0b addr=%0d cnt=%0d want 1 0 1", fail[0], faddr[0], cnt0); else n_pass++;
        @(negedge clk);
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        n_total++; if ({busy[0], en[0], st[0], fail[0]} !== {2'b00, ST_IDLE, 1'b1})
            $display("FAIL abort_beats_start: got busy=%0b st=%0d fail=%0b want 0 0 1", busy[0], st[0], fail[0]); else n_pass++;
        clear_faults();
        run_test(16'h1234, 0, 10);
        n_total++; if (busy_cnt[0] !== 34 || sb_err !== 0)
            $display("FAIL start_while_busy: got busy=%0d err=%0d want 34 0", busy_cnt[0], sb_err); else n_pass++;
        n_total++; if ({done[0], fail[0]} !== 2'b10)
            $display("FAIL restart_result: got done=%0b fail=%0b want 1 0", done[0], fail[0]); else n_pass++;
    endtask

    initial begin
        clear_faults();
        test_reset();
        test_clean();
        test_stuck_at();
        test_saturation();
        test_zero_seed();
        test_abort_priority();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
